// File: rtl/hour_chime.sv
// hour_chime: hourly/half-hourly chime sequencer; in clk_1hz cr en day_set quiet_en hour minute second (BCD), out chime busy pulses_left
module hour_chime #(
  parameter int         ON_SEC       = 1,
  parameter int         OFF_SEC      = 1,
  parameter bit         HALF_HOUR_EN = 1'b1,
  parameter logic [7:0] QUIET_START  = 8'h22,
  parameter logic [7:0] QUIET_END    = 8'h07
) (
  input  logic       clk_1hz,
  input  logic       cr,
  input  logic       en,
  input  logic       day_set,
  input  logic       quiet_en,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  output logic       chime,
  output logic       busy,
  output logic [4:0] pulses_left
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t     r_state;
  logic [3:0] r_ph;
  logic [4:0] r_pc;
  logic [7:0] w_h;
  logic [4:0] w_n;
  logic       w_valid, w_top, w_half, w_quiet, w_trig;
  assign w_h     = {4'd0, hour[7:4]} * 8'd10 + {4'd0, hour[3:0]};
  assign w_valid = hour[7:4] <= 4'd9 && hour[3:0] <= 4'd9 && w_h <= 8'd23;
  assign w_top   = {minute, second} == 16'h0000;
  assign w_half  = HALF_HOUR_EN && {minute, second} == 16'h3000;
  assign w_quiet = quiet_en && (QUIET_START <= QUIET_END ? hour >= QUIET_START && hour < QUIET_END
                                                         : hour >= QUIET_START || hour < QUIET_END);
  assign w_n     = !w_top   ? 5'd1
                 : !day_set ? (w_h == 8'd0 ? 5'd24 : w_h[4:0])
                 : w_h == 8'd0 ? 5'd12
                 : w_h > 8'd12 ? 5'(w_h - 8'd12) : w_h[4:0];
  assign w_trig  = w_valid && (w_top || w_half) && !w_quiet;
  assign chime       = r_state == ON;
  assign busy        = r_state != IDLE;
  assign pulses_left = r_pc;
  always_ff @(posedge clk_1hz) begin
    if (cr) begin
      r_state <= IDLE;
      r_pc    <= 5'd0;
      r_ph    <= 4'd0;
    end else if (!en) begin
      r_state <= IDLE;
      r_pc    <= 5'd0;
    end else begin
      case (r_state)
        IDLE: if (w_trig) begin
          r_state <= ON;
          r_pc    <= w_n;
          r_ph    <= 4'(ON_SEC - 1);
        end
        ON: if (r_ph != 4'd0) r_ph <= r_ph - 4'd1;
        else begin
          r_pc    <= r_pc - 5'd1;
          r_state <= r_pc == 5'd1 ? IDLE : OFF;
          r_ph    <= 4'(OFF_SEC - 1);
        end
        OFF: if (r_ph != 4'd0) r_ph <= r_ph - 4'd1;
        else begin
          r_state <= ON;
          r_ph    <= 4'(ON_SEC - 1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
